// File: rtl/mux2_reg.sv
// Two-input word selector: a zero-latency combinational output plus a
// registered copy with a valid flag for pipelined consumers.
module mux2_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] mux_out_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_mux_q;
  logic             r_vld;

  assign w_sel   = sel ? b : a;
  assign mux_out = w_sel;

  // The data word holds its last captured value across idle cycles, so a
  // consumer that misses out_valid still sees the most recent accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_q <= RESET_VALUE;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_mux_q <= w_sel;
      end
    end
  end

  assign mux_out_q = r_mux_q;
  assign out_valid = r_vld;

endmodule

// File: tb/tb_mux2_reg.sv
// Self-checking bench for mux2_reg: directed scenarios followed by randomized
// traffic with asynchronous reset pulses, checked against a queue-based model.
module tb_mux2_reg;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         sel, in_valid;
  logic [W-1:0] mux_out, mux_out_q;
  logic         out_valid;

  int checks   = 0;
  int failures = 0;

  // Model: every word accepted since the last reset, newest last.
  logic [W-1:0] acc_q[$];
  logic         exp_v;

  mux2_reg #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .in_valid(in_valid),
    .mux_out(mux_out), .mux_out_q(mux_out_q), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_q();
    return (acc_q.size() == 0) ? '0 : acc_q[$];
  endfunction

  // Advance one rising edge, record what the spec says is accepted, then
  // return 1 time unit after the edge so outputs are sampled off-edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (in_valid) acc_q.push_back(sel ? b : a);
      exp_v = in_valid;
    end else begin
      exp_v = 1'b0;
    end
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    acc_q.delete();
    exp_v = 1'b0;
  endtask

  task automatic test_reset_comb();
    assert_reset();
    in_valid = 1'b0;
    a = 32'd100; b = 32'd200; sel = 1'b0;
    #1;
    checks++; if (mux_out !== 32'd100) begin failures++; $display("FAIL comb_sel0 got=%0d exp=100", mux_out); end
    checks++; if (mux_out_q !== '0) begin failures++; $display("FAIL reset_q got=%h exp=0", mux_out_q); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", out_valid); end
    #50 sel = 1'b1; #1;
    checks++; if (mux_out !== 32'd200) begin failures++; $display("FAIL comb_sel1 got=%0d exp=200", mux_out); end
    #50 sel = 1'b0; #1;
    checks++; if (mux_out !== 32'd100) begin failures++; $display("FAIL comb_sel0b got=%0d exp=100", mux_out); end
    checks++; if (mux_out_q !== '0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_held q=%h vld=%b exp q=0 vld=0", mux_out_q, out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    in_valid = 1'b1; a = 32'd100; b = 32'd200; sel = 1'b1;
    tick();
    checks++; if (mux_out_q !== 32'd200 || out_valid !== 1'b1) begin failures++; $display("FAIL capture_b q=%0d vld=%b exp q=200 vld=1", mux_out_q, out_valid); end
    sel = 1'b0;
    #1;
    checks++; if (mux_out_q !== 32'd200) begin failures++; $display("FAIL capture_latency q=%0d exp=200", mux_out_q); end
    tick();
    checks++; if (mux_out_q !== 32'd100 || out_valid !== 1'b1) begin failures++; $display("FAIL capture_a q=%0d vld=%b exp q=100 vld=1", mux_out_q, out_valid); end
  endtask

  task automatic test_hold();
    in_valid = 1'b0; a = 32'd7; b = 32'd9; sel = 1'b1;
    #1;
    checks++; if (mux_out !== 32'd9) begin failures++; $display("FAIL hold_comb got=%0d exp=9", mux_out); end
    tick();
    checks++; if (mux_out_q !== 32'd100 || out_valid !== 1'b0) begin failures++; $display("FAIL hold q=%0d vld=%b exp q=100 vld=0", mux_out_q, out_valid); end
    tick();
    checks++; if (mux_out_q !== 32'd100) begin failures++; $display("FAIL hold2 q=%0d exp=100", mux_out_q); end
  endtask

  task automatic test_async_reset();
    #2;
    assert_reset();
    #1;
    checks++; if (mux_out_q !== '0 || out_valid !== 1'b0) begin failures++; $display("FAIL async_reset q=%h vld=%b exp q=0 vld=0", mux_out_q, out_valid); end
    sel = 1'b0; #1;
    checks++; if (mux_out !== 32'd7) begin failures++; $display("FAIL comb_in_reset got=%0d exp=7", mux_out); end
    in_valid = 1'b1;
    tick();
    checks++; if (mux_out_q !== '0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_no_capture q=%h vld=%b exp q=0 vld=0", mux_out_q, out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_width();
    logic [W-1:0] ones;
    ones = '1;
    in_valid = 1'b1; a = ones; b = '0; sel = 1'b0;
    tick();
    checks++; if (mux_out !== ones || mux_out_q !== ones) begin failures++; $display("FAIL ones comb=%h q=%h exp=%h", mux_out, mux_out_q, ones); end
    sel = 1'b1;
    tick();
    checks++; if (mux_out !== '0 || mux_out_q !== '0) begin failures++; $display("FAIL zeros comb=%h q=%h exp=0", mux_out, mux_out_q); end
    a = 32'hA5A5A5A5; b = 32'hA5A5A5A5;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      tick();
      checks++; if (mux_out !== 32'hA5A5A5A5 || mux_out_q !== 32'hA5A5A5A5) begin failures++; $display("FAIL equal_sel%0d comb=%h q=%h exp=a5a5a5a5", s, mux_out, mux_out_q); end
    end
  endtask

  task automatic test_midreset();
    in_valid = 1'b1; a = 32'd100; b = 32'd200; sel = 1'b1;
    tick();
    checks++; if (mux_out_q !== 32'd200 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre q=%0d vld=%b exp q=200 vld=1", mux_out_q, out_valid); end
    #2;
    assert_reset();
    #1;
    checks++; if (mux_out_q !== '0 || out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset q=%0d vld=%b exp q=0 vld=0", mux_out_q, out_valid); end
    rst_n = 1'b1;
    a = 32'd55; sel = 1'b0;
    tick();
    checks++; if (mux_out_q !== 32'd55 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_recapture q=%0d vld=%b exp q=55 vld=1", mux_out_q, out_valid); end
  endtask

  task automatic test_random();
    logic [W-1:0] eq;
    for (int i = 0; i < 300; i++) begin
      a = $urandom(); b = $urandom();
      sel = $urandom_range(0, 1);
      in_valid = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (mux_out !== (sel ? b : a)) begin failures++; $display("FAIL rnd_comb i=%0d got=%h exp=%h", i, mux_out, sel ? b : a); end
      if ($urandom_range(0, 19) == 0) begin
        assert_reset();
        #1;
        checks++; if (mux_out_q !== '0 || out_valid !== 1'b0) begin failures++; $display("FAIL rnd_reset i=%0d q=%h vld=%b exp q=0 vld=0", i, mux_out_q, out_valid); end
        rst_n = 1'b1;
      end
      tick();
      eq = exp_q();
      checks++; if (mux_out_q !== eq || out_valid !== exp_v) begin failures++; $display("FAIL rnd_reg i=%0d q=%h vld=%b exp q=%h vld=%b", i, mux_out_q, out_valid, eq, exp_v); end
    end
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; sel = 1'b0; in_valid = 1'b0; exp_v = 1'b0;
    test_reset_comb();
    test_capture();
    test_hold();
    test_async_reset();
    test_width();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
